// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - op encodings, FSM states and helpers for the HI/LO multiply/divide sequencer
package md_sequencer_pkg;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    localparam int MD_DIV_CYCLES = 33;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/md_sequencer_div_core.sv
// rtl/md_sequencer_div_core.sv - unsigned radix-2 restoring divider, one quotient bit per step
module md_sequencer_div_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    // acc holds {partial remainder, dividend bits still to consume / quotient bits produced}
    logic [63:0] acc;
    logic [31:0] dvsr;
    logic [32:0] trial;

    // Partial remainder stays below the divisor, so the shifted value fits in 33 bits
    assign trial     = acc[63:31] - {1'b0, dvsr};
    assign quotient  = acc[31:0];
    assign remainder = acc[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            dvsr <= '0;
        end else if (init) begin
            acc  <= {32'b0, dividend};
            dvsr <= divisor;
        end else if (step) begin
            if (!trial[32])
                acc <= {trial[31:0], acc[30:0], 1'b1};
            else
                acc <= {acc[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step divide, MTHI/MTLO
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] MUL_CNT_INIT = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_CNT_INIT = 6'(MD_DIV_CYCLES - 1);

    md_state_t   state;
    logic [5:0]  cnt;
    logic [63:0] mul_prod;
    logic        a_neg, b_neg;

    logic        is_div, is_signed, launch, div_step;
    logic [31:0] a_mag, b_mag, quotient, remainder;
    logic [63:0] prod_next;

    assign is_div    = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    assign is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    assign launch    = (state == MD_IDLE) && start && !cancel;
    assign div_step  = (state == MD_DIV) && !cancel && (cnt != 6'd0);

    assign a_mag = is_signed ? abs32(src_a) : src_a;
    assign b_mag = is_signed ? abs32(src_b) : src_b;

    // Sign-extending to 64 bits makes the truncated product the two's-complement result
    assign prod_next = is_signed ? ({{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b})
                                 : ({32'b0, src_a} * {32'b0, src_b});

    md_sequencer_div_core u_div_core (
        .clk       (clk),
        .reset     (reset),
        .init      (launch && is_div),
        .step      (div_step),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            mul_prod <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (launch) begin
                        mul_prod <= prod_next;
                        a_neg    <= is_signed & src_a[31];
                        b_neg    <= is_signed & src_b[31];
                        cnt      <= is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
                        state    <= is_div ? MD_DIV : MD_MUL;
                        busy     <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MD_MUL: begin
                    if (cancel) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == 6'd0) begin
                        {hi, lo} <= mul_prod;
                        done     <= 1'b1;
                        state    <= MD_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                MD_DIV: begin
                    if (cancel) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == 6'd0) begin
                        // Quotient truncates toward zero; remainder takes the dividend's sign
                        lo    <= (a_neg ^ b_neg) ? -quotient : quotient;
                        hi    <= a_neg ? -remainder : remainder;
                        done  <= 1'b1;
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer against an arithmetic HI/LO model
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, cancel, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total  = 0;
    int passed = 0;
    logic [31:0] mh, ml;

    md_sequencer #(.MULT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference results straight from the arithmetic definition of each instruction
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; {eh, el} = p; end
            2'b01: begin u = {32'b0, a} * {32'b0, b}; {eh, el} = u; end
            2'b10: begin
                if (b == 0) begin
                    el = a[31] ? 32'h1 : 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        int   cycles;
        logic early;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        early  = 1'b0;
        while (busy && cycles < 100) begin
            cycles++;
            if (done) early = 1'b1;
            @(negedge clk);
        end
        model(o, a, b, mh, ml);
        check({tag, " busy_cycles"}, 32'(cycles), o[1] ? 32'd33 : 32'd4);
        check({tag, " early_done"}, {31'b0, early}, 32'd0);
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " hi"}, hi, mh);
        check({tag, " lo"}, lo, ml);
        @(negedge clk);
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic        seen_done;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3);
        check("mult_neg hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg lo_const", lo, 32'hFFFF_FFFA);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max lo_const", lo, 32'h0000_0001);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_neg lo_const", lo, 32'hFFFF_FFFD);
        check("div_neg hi_const", hi, 32'hFFFF_FFFF);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
        check("divu_100_7 lo_const", lo, 32'd14);
        check("divu_100_7 hi_const", hi, 32'd2);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf lo_const", lo, 32'h8000_0000);
        check("div_ovf hi_const", hi, 32'd0);
        run_op("divu_zero", 2'b11, 32'h0BAD_F00D, 32'd0);
        check("divu_zero lo_const", lo, 32'hFFFF_FFFF);
        check("divu_zero hi_const", hi, 32'h0BAD_F00D);
        run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0);

        // MTHI / MTLO while idle
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        @(negedge clk); lo_we = 1'b0;
        check("mthi", hi, 32'h1234_5678);
        check("mtlo", lo, 32'h9ABC_DEF0);
        mh = 32'h1234_5678; ml = 32'h9ABC_DEF0;

        // start beats a same-cycle MTHI
        start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        check("start_vs_mthi busy", {31'b0, busy}, 32'd1);
        check("start_vs_mthi hi", hi, mh);
        repeat (5) @(negedge clk);
        check("start_vs_mthi commit_lo", lo, 32'd30);
        check("start_vs_mthi commit_hi", hi, 32'd0);
        mh = 32'd0; ml = 32'd30;

        // cancel during an idle start: start dropped, MTLO still honoured
        start = 1'b1; cancel = 1'b1; op = 2'b10; lo_we = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk); start = 1'b0; cancel = 1'b0; lo_we = 1'b0;
        check("idle_cancel busy", {31'b0, busy}, 32'd0);
        check("idle_cancel lo", lo, 32'hCAFE_0001);
        ml = 32'hCAFE_0001;

        // cancel in the 10th busy cycle of a divide
        start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        check("div_cancel busy_before", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        check("div_cancel busy", {31'b0, busy}, 32'd0);
        seen_done = done;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("div_cancel no_done", {31'b0, seen_done}, 32'd0);
        check("div_cancel hi", hi, mh);
        check("div_cancel lo", lo, ml);

        // cancel coinciding with the multiply commit edge
        start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("commit_cancel busy_before", {31'b0, busy}, 32'd1);
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        check("commit_cancel busy", {31'b0, busy}, 32'd0);
        check("commit_cancel done", {31'b0, done}, 32'd0);
        check("commit_cancel lo", lo, ml);

        // reset in the middle of a divide
        start = 1'b1; op = 2'b11; src_a = 32'd12345; src_b = 32'd17;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("mid_reset busy", {31'b0, busy}, 32'd0);
        check("mid_reset hi", hi, 32'd0);
        check("mid_reset lo", lo, 32'd0);

        // randomized ops against the model, with occasional corner operands
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
